pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush/miss controller for the 5-stage pipelined TSC core with split I/D caches. It observes hazard sources (load-use dependences, EX-stage redirects, cache busy levels, WB halt) and drives the shared control lines Stall, Flush, I_miss, D_miss and Halt. These lines feed the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It holds a miss-sequencing FSM and saturating performance counters.

## Interface
- CNT_W, 16, width of each performance counter
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- ID_rs_addr  in  2  source register A of instruction in ID
- ID_rt_addr  in  2  source register B of instruction in ID
- ID_UseRs  in  1  ID instruction reads rs
- ID_UseRt  in  1  ID instruction reads rt
- EX_MemRead  in  1  EX instruction is a load
- EX_RegWrite  in  1  EX instruction writes a register
- EX_reg_write_addr  in  2  EX destination register
- EX_redirect  in  1  EX resolved a taken branch/jump (PC mispredicted)
- ic_busy  in  1  I-cache miss in progress (level)
- dc_busy  in  1  D-cache miss in progress (level)
- WB_Halt  in  1  HLT instruction reached WB
- Stall  out  1  freeze PC and IF/ID, bubble ID/EX
- Flush  out  1  squash IF/ID and bubble ID/EX
- I_miss  out  1  freeze PC
- D_miss  out  1  freeze all pipeline registers
- Halt  out  1  processor halted
- state  out  2  FSM state: RUN=0, DMISS=1, IMISS=2, HALT=3
- stall_cnt  out  CNT_W  cycles with Stall=1
- flush_cnt  out  CNT_W  cycles with Flush=1
- miss_cnt  out  CNT_W  cycles spent in DMISS or IMISS

## Operation
- Load-use hazard lu = EX_MemRead & EX_RegWrite & ((ID_UseRs & rs==EX_reg_write_addr) | (ID_UseRt & rt==EX_reg_write_addr)).
- FSM, registered, reset to RUN:
  - From any state, WB_Halt=1 -> HALT. HALT is absorbing until reset. This has the highest priority.
  - RUN: dc_busy -> DMISS; else ic_busy -> IMISS; else RUN.
  - DMISS: dc_busy -> DMISS; else ic_busy -> IMISS; else RUN.
  - IMISS: dc_busy -> DMISS, because the D side is older and preempts; else ic_busy -> IMISS; else RUN.
- Outputs are combinational from current inputs and state, so the pipeline freezes in the same cycle the busy level is seen:
  - Halt = (state==HALT) | WB_Halt.
  - D_miss = !Halt & dc_busy.
  - I_miss = !Halt & !dc_busy & ic_busy.
  - Flush = !Halt & !dc_busy & EX_redirect.
  - Stall = !Halt & !dc_busy & !Flush & lu.
- Priority rules:
  - Flush beats Stall, because the dependent ID instruction is squashed anyway.
  - D_miss masks Stall, Flush and I_miss. The EX redirect is held by the frozen latches and re-evaluated on resume.
  - I_miss may coexist with Flush or Stall.
- Counters:
  - Each counter is incremented when its condition is true, evaluated at the clock edge.
  - miss_cnt condition: (D_miss | I_miss).
  - Counters saturate at 2^CNT_W−1 (no wrap).
  - Counters are frozen while Halt=1.
- Reset (reset_n low at edge):
  - state=RUN and all counters=0.
  - While reset_n=0, all control outputs (Stall, Flush, I_miss, D_miss, Halt) are forced to 0, regardless of inputs.

## Timing
- Control outputs have 0-cycle latency from inputs.
- state and counters update 1 cycle after the qualifying input.
- A 1-cycle dc_busy pulse gives D_miss for exactly that cycle, and state=DMISS in the next cycle.
- Halt rises in the same cycle as WB_Halt and stays 1 after WB_Halt falls.
- Reset mid-miss: the next cycle shows state=RUN, and counters=0 after the edge.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state encoding constants RUN/DMISS/IMISS/HALT;
  - the register address width (2);
  - the CNT_W default.
- WORD_SIZE is not needed.
- One sub-module, `sat_counter` (CNT_W, inc, freeze, reset_n), is instantiated three times.
- The hazard compare and FSM live in the top module.

## Test plan
- Load-use:
  - Stimulus: EX_MemRead=1, EX_RegWrite=1, EX_reg_write_addr=2, ID_rs_addr=2, ID_UseRs=1 for 1 cycle.
  - Response: Stall=1 in that cycle, Flush=0, stall_cnt=1 after the edge.
  - Repeat with ID_UseRs=0: Stall=0.
- Stall vs. flush:
  - Stimulus: lu true plus EX_redirect=1.
  - Response: Flush=1, Stall=0, flush_cnt increments, stall_cnt unchanged.
- Miss overlap:
  - Stimulus: ic_busy=1 for 5 cycles, with dc_busy=1 on cycles 2–3.
  - Response: state sequence RUN→IMISS→DMISS→DMISS→IMISS→IMISS→RUN; I_miss=0 while dc_busy=1; miss_cnt=5.
- Halt:
  - Stimulus: WB_Halt=1 for 1 cycle, followed by dc_busy=1 and lu true.
  - Response: Halt=1 from that cycle onward; state=HALT; all other outputs 0; counters frozen.
- Saturation:
  - Stimulus: CNT_W=4, lu held true for 20 cycles.
  - Response: stall_cnt=15, with no wrap.
- Reset:
  - Stimulus: reset_n=0 for 1 edge while in DMISS with counters non-zero.
  - Response: state=RUN and all counters=0 after the edge; outputs 0 during reset.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   state_t    : miss-sequencing FSM encoding (RUN/DMISS/IMISS/HALT)
//   REG_AW     : register address width
//   CNT_W_DEF  : default performance counter width
package pipe_ctrl_pkg;

   localparam int unsigned REG_AW    = 2;
   localparam int unsigned CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DMISS = 2'd1,
      IMISS = 2'd2,
      HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter used for the controller's
// performance statistics.
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset, clears the count
//   inc      : count this cycle
//   freeze   : hold the count regardless of inc
//   count    : current value, sticks at all-ones
module sat_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             freeze,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!reset_n)
         count <= '0;
      else if (inc && !freeze && (count != '1))
         count <= count + ONE;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush/miss controller for the
// 5-stage TSC core with split I/D caches.
//   Inputs : ID source regs and use flags, EX load/write/dest info,
//            EX_redirect, cache busy levels (ic_busy, dc_busy), WB_Halt.
//   Outputs: Stall, Flush, I_miss, D_miss, Halt (combinational, forced
//            low while reset_n=0), state (miss FSM), and saturating
//            counters stall_cnt, flush_cnt, miss_cnt (frozen while halted).
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [REG_AW-1:0] ID_rs_addr,
   input  logic [REG_AW-1:0] ID_rt_addr,
   input  logic              ID_UseRs,
   input  logic              ID_UseRt,
   input  logic              EX_MemRead,
   input  logic              EX_RegWrite,
   input  logic [REG_AW-1:0] EX_reg_write_addr,
   input  logic              EX_redirect,
   input  logic              ic_busy,
   input  logic              dc_busy,
   input  logic              WB_Halt,
   output logic              Stall,
   output logic              Flush,
   output logic              I_miss,
   output logic              D_miss,
   output logic              Halt,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   state_t state_q;
   logic   load_use;
   logic   active;

   assign load_use = EX_MemRead & EX_RegWrite &
                     ((ID_UseRs & (ID_rs_addr == EX_reg_write_addr)) |
                      (ID_UseRt & (ID_rt_addr == EX_reg_write_addr)));

   // Control lines are live only out of reset and when not halted;
   // a D-side miss freezes everything, so it masks the other three.
   assign Halt   = reset_n & ((state_q == HALT) | WB_Halt);
   assign active = reset_n & ~Halt;
   assign D_miss = active & dc_busy;
   assign I_miss = active & ~dc_busy & ic_busy;
   assign Flush  = active & ~dc_busy & EX_redirect;
   assign Stall  = active & ~dc_busy & ~Flush & load_use;

   assign state = state_q;

   // Transitions out of RUN, DMISS and IMISS are identical (D side
   // first, then I side), so only HALT needs its own branch.
   always_ff @(posedge clk) begin
      if (!reset_n)
         state_q <= RUN;
      else if (WB_Halt || (state_q == HALT))
         state_q <= HALT;
      else if (dc_busy)
         state_q <= DMISS;
      else if (ic_busy)
         state_q <= IMISS;
      else
         state_q <= RUN;
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (Stall),
      .freeze  (Halt),
      .count   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (Flush),
      .freeze  (Halt),
      .count   (flush_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (D_miss | I_miss),
      .freeze  (Halt),
      .count   (miss_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: two instances (16-bit and 4-bit
// counters) share stimulus; a behavioural model checks every cycle and
// directed sequences pin literal expectations.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] rs, rt, wa;
   logic       use_rs, use_rt, mr, rw, redir, ic, dc, wbh;

   logic        st_a, fl_a, im_a, dm_a, h_a;
   logic [1:0]  state_a;
   logic [15:0] sc_a, fc_a, mc_a;
   logic        st_b, fl_b, im_b, dm_b, h_b;
   logic [1:0]  state_b;
   logic [3:0]  sc_b, fc_b, mc_b;

   int total = 0;
   int bad   = 0;

   // Model: state as a small integer and unbounded event counts.
   int mstate = 0;
   int mstall = 0, mflush = 0, mmiss = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(16)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .ID_rs_addr(rs), .ID_rt_addr(rt), .ID_UseRs(use_rs), .ID_UseRt(use_rt),
      .EX_MemRead(mr), .EX_RegWrite(rw), .EX_reg_write_addr(wa),
      .EX_redirect(redir), .ic_busy(ic), .dc_busy(dc), .WB_Halt(wbh),
      .Stall(st_a), .Flush(fl_a), .I_miss(im_a), .D_miss(dm_a), .Halt(h_a),
      .state(state_a), .stall_cnt(sc_a), .flush_cnt(fc_a), .miss_cnt(mc_a)
   );

   pipeline_hazard_ctrl #(.CNT_W(4)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .ID_rs_addr(rs), .ID_rt_addr(rt), .ID_UseRs(use_rs), .ID_UseRt(use_rt),
      .EX_MemRead(mr), .EX_RegWrite(rw), .EX_reg_write_addr(wa),
      .EX_redirect(redir), .ic_busy(ic), .dc_busy(dc), .WB_Halt(wbh),
      .Stall(st_b), .Flush(fl_b), .I_miss(im_b), .D_miss(dm_b), .Halt(h_b),
      .state(state_b), .stall_cnt(sc_b), .flush_cnt(fc_b), .miss_cnt(mc_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sat(input int c, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   // Per-cycle compare against the model, then advance the model.
   always @(negedge clk) begin
      bit lu, h, dm, im, fl, sl;
      lu = mr && rw && ((use_rs && rs == wa) || (use_rt && rt == wa));
      h  = reset_n && (mstate == 3 || wbh);
      dm = reset_n && !h && dc;
      im = reset_n && !h && !dc && ic;
      fl = reset_n && !h && !dc && redir;
      sl = reset_n && !h && !dc && !fl && lu;

      chk("m_state_a", 32'(state_a), 32'(mstate));
      chk("m_state_b", 32'(state_b), 32'(mstate));
      chk("m_halt_a",  32'(h_a),  32'(h));
      chk("m_halt_b",  32'(h_b),  32'(h));
      chk("m_dmiss_a", 32'(dm_a), 32'(dm));
      chk("m_dmiss_b", 32'(dm_b), 32'(dm));
      chk("m_imiss_a", 32'(im_a), 32'(im));
      chk("m_imiss_b", 32'(im_b), 32'(im));
      chk("m_flush_a", 32'(fl_a), 32'(fl));
      chk("m_flush_b", 32'(fl_b), 32'(fl));
      chk("m_stall_a", 32'(st_a), 32'(sl));
      chk("m_stall_b", 32'(st_b), 32'(sl));
      chk("m_sc_a", 32'(sc_a), 32'(sat(mstall, 16)));
      chk("m_fc_a", 32'(fc_a), 32'(sat(mflush, 16)));
      chk("m_mc_a", 32'(mc_a), 32'(sat(mmiss, 16)));
      chk("m_sc_b", 32'(sc_b), 32'(sat(mstall, 4)));
      chk("m_fc_b", 32'(fc_b), 32'(sat(mflush, 4)));
      chk("m_mc_b", 32'(mc_b), 32'(sat(mmiss, 4)));

      if (!reset_n) begin
         mstate = 0; mstall = 0; mflush = 0; mmiss = 0;
      end else begin
         if (mstate == 3 || wbh) mstate = 3;
         else if (dc)            mstate = 1;
         else if (ic)            mstate = 2;
         else                    mstate = 0;
         mstall += int'(sl);
         mflush += int'(fl);
         mmiss  += int'(dm | im);
      end
   end

   task automatic idle();
      reset_n = 1'b1;
      rs = 2'd0; rt = 2'd0; wa = 2'd0;
      use_rs = 1'b0; use_rt = 1'b0; mr = 1'b0; rw = 1'b0;
      redir = 1'b0; ic = 1'b0; dc = 1'b0; wbh = 1'b0;
   endtask

   task automatic set_lu();
      mr = 1'b1; rw = 1'b1; wa = 2'd2; rs = 2'd2; use_rs = 1'b1;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      nxt();
      idle();
   endtask

   initial begin
      // Reset with every input asserted: outputs must stay low.
      idle();
      reset_n = 1'b0; wbh = 1'b1; dc = 1'b1; ic = 1'b1; redir = 1'b1;
      set_lu();
      @(negedge clk);
      chk("rst_halt",  32'(h_a),  0);
      chk("rst_dmiss", 32'(dm_a), 0);
      chk("rst_imiss", 32'(im_a), 0);
      chk("rst_flush", 32'(fl_a), 0);
      chk("rst_stall", 32'(st_a), 0);
      nxt();
      idle();
      @(negedge clk);
      chk("rst_state", 32'(state_a), 0);
      chk("rst_scnt",  32'(sc_a), 0);

      // Load-use stall
      nxt(); set_lu();
      @(negedge clk);
      chk("lu_stall", 32'(st_a), 1);
      chk("lu_flush", 32'(fl_a), 0);
      nxt(); set_lu(); use_rs = 1'b0;
      @(negedge clk);
      chk("lu_scnt",    32'(sc_a), 1);
      chk("nolu_stall", 32'(st_a), 0);

      // Flush beats stall
      nxt(); set_lu(); redir = 1'b1;
      @(negedge clk);
      chk("fvs_flush", 32'(fl_a), 1);
      chk("fvs_stall", 32'(st_a), 0);
      nxt(); idle();
      @(negedge clk);
      chk("fvs_fcnt", 32'(fc_a), 1);
      chk("fvs_scnt", 32'(sc_a), 1);

      // Miss overlap: ic for 5 cycles, dc on cycles 2-3
      for (int c = 1; c <= 7; c++) begin
         nxt(); idle();
         ic = (c <= 5);
         dc = (c == 2 || c == 3);
         @(negedge clk);
         case (c)
            1: chk("ov_st1", 32'(state_a), 0);
            2: begin chk("ov_st2", 32'(state_a), 2); chk("ov_im2", 32'(im_a), 0); chk("ov_dm2", 32'(dm_a), 1); end
            3: begin chk("ov_st3", 32'(state_a), 1); chk("ov_im3", 32'(im_a), 0); end
            4: chk("ov_st4", 32'(state_a), 1);
            5: chk("ov_st5", 32'(state_a), 2);
            6: begin chk("ov_st6", 32'(state_a), 2); chk("ov_mcnt", 32'(mc_a), 5); end
            default: chk("ov_st7", 32'(state_a), 0);
         endcase
      end

      // Saturation on the 4-bit instance
      nxt(); do_reset();
      for (int c = 0; c < 20; c++) begin
         set_lu();
         nxt();
      end
      idle();
      @(negedge clk);
      chk("sat_b", 32'(sc_b), 15);
      chk("sat_a", 32'(sc_a), 20);

      // Randomized phase
      for (int c = 0; c < 3000; c++) begin
         nxt();
         reset_n = ($urandom_range(79) != 0);
         rs = 2'($urandom_range(3)); rt = 2'($urandom_range(3)); wa = 2'($urandom_range(3));
         use_rs = 1'($urandom); use_rt = 1'($urandom);
         mr = 1'($urandom); rw = ($urandom_range(3) != 0);
         redir = ($urandom_range(4) == 0);
         ic = ($urandom_range(9) < 3);
         dc = ($urandom_range(3) == 0);
         wbh = ($urandom_range(299) == 0);
      end

      // Reset mid-DMISS with non-zero counters
      nxt(); do_reset();
      set_lu();
      nxt(); idle(); dc = 1'b1;
      nxt(); idle(); dc = 1'b1;
      nxt(); idle(); dc = 1'b1; reset_n = 1'b0;
      @(negedge clk);
      chk("rm_state_pre", 32'(state_a), 1);
      chk("rm_mcnt_pre",  32'(mc_a), 2);
      chk("rm_scnt_pre",  32'(sc_a), 1);
      chk("rm_dmiss",     32'(dm_a), 0);
      nxt(); idle();
      @(negedge clk);
      chk("rm_state", 32'(state_a), 0);
      chk("rm_scnt",  32'(sc_a), 0);
      chk("rm_mcnt",  32'(mc_a), 0);

      // Halt
      nxt(); set_lu();
      nxt(); idle(); wbh = 1'b1;
      @(negedge clk);
      chk("h_halt0", 32'(h_a), 1);
      for (int c = 0; c < 3; c++) begin
         nxt(); idle(); set_lu(); dc = 1'b1; ic = 1'b1; redir = 1'b1;
         @(negedge clk);
         chk("h_halt",  32'(h_a), 1);
         chk("h_state", 32'(state_a), 3);
         chk("h_dmiss", 32'(dm_a), 0);
         chk("h_imiss", 32'(im_a), 0);
         chk("h_flush", 32'(fl_a), 0);
         chk("h_stall", 32'(st_a), 0);
      end
      nxt(); idle();
      @(negedge clk);
      chk("h_scnt", 32'(sc_a), 1);
      chk("h_mcnt", 32'(mc_a), 0);
      chk("h_fcnt", 32'(fc_a), 0);

      nxt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
